// File: rtl/fpu_op_scheduler.sv
// fpu_op_scheduler: operand sequencer and result capture in front of the fpu adder.
// Operand pairs are queued in a small FIFO. One pair at a time is presented to the fpu and
// held for SETTLE_CYCLES edges. The fpu output is then captured into a result register that
// is offered downstream on a valid/ready interface.
// Ports:
//   clock100KHz, reset       clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready        operand-pair handshake; in_a/in_b are the operands
//   fpu_op_a/fpu_op_b        registered operands driving the fpu
//   fpu_data/fpu_status      fpu result, sampled at the end of the settle window
//   res_valid/res_ready      result handshake; res_data/res_status hold the captured result
//   fifo_level               entries currently queued
//   busy                     an operation is in flight or pairs are queued
module fpu_op_scheduler #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 100
) (
  input  logic                          clock100KHz,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_a,
  input  logic [31:0]                   in_b,
  output logic [31:0]                   fpu_op_a,
  output logic [31:0]                   fpu_op_b,
  input  logic [31:0]                   fpu_data,
  input  logic [3:0]                    fpu_status,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [31:0]                   res_data,
  output logic [3:0]                    res_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       level_q;
  logic [31:0]         op_a_q, op_b_q;
  logic                res_valid_q;
  logic [31:0]         res_data_q;
  logic [3:0]          res_status_q;
  logic [63:0]         mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, push, load, capture, res_clear;
  logic [63:0] head;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == (PtrW + 1)'(FIFO_DEPTH));
  // Acceptance ignores a same-edge pop, so a full FIFO never takes a push.
  assign push       = in_valid && !fifo_full;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    capture   = 1'b0;
    res_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (res_ready) begin
          res_clear = 1'b1;
          if (!fifo_empty) begin
            load    = 1'b1;
            state_d = StWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (load) begin
      cnt_d = CntW'(SETTLE_CYCLES - 1);
    end
  end

  always_ff @(posedge clock100KHz or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_status_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        op_a_q   <= head[63:32];
        op_b_q   <= head[31:0];
      end
      if (push && !load) begin
        level_q <= level_q + 1'b1;
      end else if (!push && load) begin
        level_q <= level_q - 1'b1;
      end
      if (capture) begin
        res_valid_q  <= 1'b1;
        res_data_q   <= fpu_data;
        res_status_q <= fpu_status;
      end else if (res_clear) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock100KHz) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  assign in_ready   = !fifo_full;
  assign fpu_op_a   = op_a_q;
  assign fpu_op_b   = op_b_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_status = res_status_q;
  assign fifo_level = level_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Bench for fpu_op_scheduler with a combinational fpu stub (sum of operands, status = op_a[3:0]).
// A scoreboard records every accepted pair and expects its result in push order.
module tb_fpu_op_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic [31:0] fpu_op_a, fpu_op_b, fpu_data;
  logic [3:0]  fpu_status;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_status;
  logic [2:0]  fifo_level;
  logic        busy;

  always #5 clk = ~clk;

  assign fpu_data   = fpu_op_a + fpu_op_b;
  assign fpu_status = fpu_op_a[3:0];

  fpu_op_scheduler #(
    .FIFO_DEPTH   (4),
    .SETTLE_CYCLES(100)
  ) dut (
    .clock100KHz(clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .fpu_op_a   (fpu_op_a),
    .fpu_op_b   (fpu_op_b),
    .fpu_data   (fpu_data),
    .fpu_status (fpu_status),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_status (res_status),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int n_results = 0;

  logic [35:0] exp_q[$];
  logic        hold_prev = 1'b0;
  logic [31:0] prev_data;
  logic [3:0]  prev_status;
  logic [35:0] exp_item;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!res_valid && n < max) begin
      step();
      n++;
    end
    check("res_valid timeout", res_valid, 1'b1);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n = 0;
    while (!in_ready && n < 2000) begin
      step();
      n++;
    end
    check("in_ready timeout", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < max) begin
      step();
      n++;
    end
    check("drain timeout", exp_q.size(), 0);
    step();
    step();
  endtask

  // Scoreboard: pushes enqueue the expected result, handshakes dequeue it.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("result held stable", {res_valid, res_data, res_status},
              {1'b1, prev_data, prev_status});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_a + in_b, in_a[3:0]});
      end
      if (res_valid && res_ready) begin
        n_results++;
        check("result pending in model", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_item = exp_q.pop_front();
          check("result data/status", {res_data, res_status}, exp_item);
        end
      end
      hold_prev   = res_valid && !res_ready;
      prev_data   = res_data;
      prev_status = res_status;
    end
  end

  initial begin
    int n, acc, base, pushed;
    logic took, seen;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    res_ready = 1'b1;
    #1;
    check("reset outputs",
          {in_ready, res_valid, fpu_op_a, fpu_op_b, res_data, res_status, fifo_level, busy},
          {1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 3'd0, 1'b0});
    step();
    step();
    reset = 1'b0;
    step();

    // Single operation latency: capture 101 edges after the accept edge.
    push(32'h3E000000, 32'h3E000000);
    wait_valid(300, n);
    check("latency", n, 101);
    check("t1 result", {res_data, res_status}, {32'h7C000000, 4'h0});
    drain(500);

    // Back-to-back pairs; each next load happens on the previous result's handshake edge.
    in_valid = 1'b1;
    in_a = 32'h40000000; in_b = 32'hC0000000; step();
    in_a = 32'h42000000; in_b = 32'h40000000; step();
    in_a = 32'h00000001; in_b = 32'h00000002; step();
    in_valid = 1'b0;
    wait_valid(300, n);
    check("t2 r0", {res_data, res_status}, {32'h00000000, 4'h0});
    step();
    check("t2 load1", {res_valid, fpu_op_a, fpu_op_b}, {1'b0, 32'h42000000, 32'h40000000});
    wait_valid(300, n);
    check("t2 r1", {res_data, res_status}, {32'h82000000, 4'h0});
    step();
    check("t2 load2", {res_valid, fpu_op_a, fpu_op_b}, {1'b0, 32'h00000001, 32'h00000002});
    wait_valid(300, n);
    check("t2 r2", {res_data, res_status}, {32'h00000003, 4'h1});
    step();
    check("t2 idle", busy, 1'b0);

    // Capacity under stall: one in flight plus a full FIFO.
    res_ready = 1'b0;
    acc       = 0;
    base      = n_results;
    in_valid  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_a = 32'h1000 * (acc + 1) + acc;
      in_b = 32'h7 + acc;
      took = in_ready;
      step();
      if (took) acc++;
    end
    in_valid = 1'b0;
    check("t3 accepted", acc, 5);
    check("t3 full", {in_ready, fifo_level}, {1'b0, 3'd4});
    res_ready = 1'b1;
    drain(1500);
    check("t3 drained count", n_results - base, 5);
    check("t3 idle", {busy, fifo_level}, {1'b0, 3'd0});

    // Stalled result: everything the consumer and fpu see stays put.
    res_ready = 1'b0;
    push(32'h1234567A, 32'h01010101);
    wait_valid(300, n);
    for (int c = 0; c < 20; c++) begin
      check("t4 stable", {res_valid, res_data, res_status, fpu_op_a, fpu_op_b},
            {1'b1, 32'h1335577B, 4'hA, 32'h1234567A, 32'h01010101});
      step();
    end
    res_ready = 1'b1;
    drain(300);

    // Push and pop on the same edge with one entry queued.
    base     = n_results;
    in_valid = 1'b1;
    in_a = 32'h00000005; in_b = 32'h00000010; step();
    check("t5 level after push", fifo_level, 3'd1);
    in_a = 32'h0000000C; in_b = 32'h00000020; step();
    in_valid = 1'b0;
    check("t5 level push+pop", fifo_level, 3'd1);
    check("t5 loaded", {fpu_op_a, fpu_op_b}, {32'h00000005, 32'h00000010});
    drain(600);
    check("t5 both processed", n_results - base, 2);

    // Reset mid-WAIT with two pairs queued.
    in_valid = 1'b1;
    in_a = 32'h00000011; in_b = 32'h1; step();
    in_a = 32'h00000022; in_b = 32'h2; step();
    in_a = 32'h00000033; in_b = 32'h3; step();
    in_valid = 1'b0;
    check("t6 queued", fifo_level, 3'd2);
    for (int c = 0; c < 48; c++) step();
    base  = n_results;
    reset = 1'b1;
    #1;
    check("t6 async reset",
          {res_valid, fpu_op_a, fifo_level, busy, in_ready},
          {1'b0, 32'h0, 3'd0, 1'b0, 1'b1});
    step();
    reset = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (res_valid) seen = 1'b1;
    end
    check("t6 no result after reset", {seen, busy}, {1'b0, 1'b0});
    check("t6 result count", n_results - base, 0);

    // Random traffic with random consumer stalls.
    base   = n_results;
    pushed = 0;
    n      = 0;
    while ((pushed < 12 || exp_q.size() != 0 || res_valid) && n < 8000) begin
      in_valid  = (pushed < 12) && ($urandom_range(2) != 0);
      in_a      = $urandom;
      in_b      = $urandom;
      res_ready = $urandom_range(1) != 0;
      took      = in_valid && in_ready;
      step();
      if (took) pushed++;
      n++;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    step();
    step();
    check("rand completion", {pushed, exp_q.size()}, {32'd12, 32'd0});
    check("rand result count", n_results - base, 12);
    check("rand idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
